pwm_peripheral: RTL
===================

// Module: pwm_peripheral
// PURPOSE
//  Consumes the five configuration bytes written over SPI (output enables,
//  PWM enables, duty cycle) and drives 16 user outputs. Each output is forced
//  low, held high, or driven by a shared 8-bit PWM waveform. It sits directly
//  downstream of the SPI register block. Its outputs go straight to the pads.
// PARAMETERS
//  CLK_DIV  13  clk cycles per PWM counter tick (>=1); 10 MHz/13/256 ~ 3 kHz
//  CNT_W    8   PWM counter / duty width; fixed at 8 for this design
// PORTS
//  clk              in   1   system clock; single clock domain
//  rst              in   1   reset, synchronous, active-high
//  en_reg_out_7_0   in   8   output enable, bits 7:0
//  en_reg_out_15_8  in   8   output enable, bits 15:8
//  en_reg_pwm_7_0   in   8   PWM mode select, bits 7:0
//  en_reg_pwm_15_8  in   8   PWM mode select, bits 15:8
//  pwm_duty_cycle   in   8   requested duty; 0x00=0%, 0xFF=100%
//  out              out  16  registered user outputs
//  period_start     out  1   1-cycle pulse when the PWM counter wraps to 0
// BEHAVIOUR
//  - Reset: while rst is high at a clk edge, all state is cleared:
//    prescaler=0, cnt=0, duty_active=0x00, out=16'h0000, period_start=0.
//    Reset mid-period: out reads 0 from the first edge with rst high.
//    After rst falls, the first period starts at cnt=0.
//  - Prescaler: counts 0..CLK_DIV-1. tick=1 when prescaler==CLK_DIV-1,
//    then prescaler wraps to 0. With CLK_DIV=1, tick=1 every cycle.
//  - Counter: cnt advances by 1 on each tick and wraps 255->0 (mod 256).
//    A period is 256*CLK_DIV clk cycles (3328 at default).
//  - period_start: registered; asserted for exactly the one cycle after
//    the wrap (cnt now 0).
//  - Duty shadow: duty_active <= pwm_duty_cycle only on the wrap
//    (tick && cnt==255). Changes made mid-period take effect at the next
//    period and never cause a runt pulse. Several changes within one
//    period: only the value present at the wrap is used.
//  - pwm_sig = (duty_active==8'hFF) ? 1 : (cnt < duty_active).
//    0x00 gives constant low. 0xFF gives constant high, with no 1-tick gap.
//    Otherwise high for duty_active ticks starting at cnt=0.
//  - Per-bit select for i in 0..15; en_out/en_pwm are the {15_8,7_0}
//    concatenations:
//      en_out[i]==0                  -> out[i]=0 (wins over en_pwm)
//      en_out[i]==1 && en_pwm[i]==0  -> out[i]=1
//      en_out[i]==1 && en_pwm[i]==1  -> out[i]=pwm_sig
//  - Latency: out is registered. Enable changes show on out 1 clk after
//    the input changes. Enables are applied immediately, not at the
//    period boundary.
//  - All PWM-mode bits share one counter, so they switch in phase.
// STRUCTURE
//  - pwm_pkg holds: CNT_W, DUTY_FULL=8'hFF, and the register address
//    constants (0x00..0x04) shared with the SPI block.
//  - Sub-module pwm_timebase (prescaler, cnt, tick, wrap, period_start).
//    The top level holds the duty shadow, the compare, and the
//    per-bit output mux/register.
// TESTING
//  - rst high 3 clks mid-run -> out==0 and cnt==0 during reset; first
//    period_start comes 256*13 clks after rst falls.
//  - en_out=16'hFFFF, en_pwm=0, duty=0x80 -> out==16'hFFFF, 1 clk after
//    the write.
//  - en_out=16'h0001, en_pwm=16'h0001, duty=0x80 -> out[0] high 1664 clks
//    and low 1664 clks per period; out[15:1]==0.
//  - duty=0x00 -> out[0] never high; duty=0xFF -> out[0] never low across
//    3 periods; duty=0x01 -> out[0] high exactly 13 clks per period.
//  - duty changed 0x40->0xC0 at cnt=100 -> current period keeps 832-clk
//    high time; next period has 2496.
//  - en_out=0, en_pwm=16'hFFFF, duty=0xFF -> out==0 (output enable wins).

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM output block and the SPI register map that feeds it.
package pwm_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MAX   = 8'hFF;

  localparam logic [7:0] ADDR_EN_OUT_7_0  = 8'h00;
  localparam logic [7:0] ADDR_EN_OUT_15_8 = 8'h01;
  localparam logic [7:0] ADDR_EN_PWM_7_0  = 8'h02;
  localparam logic [7:0] ADDR_EN_PWM_15_8 = 8'h03;
  localparam logic [7:0] ADDR_DUTY        = 8'h04;

  // Full scale is special-cased so 0xFF stays high through cnt==255 instead of dropping for one tick.
  function automatic logic pwm_level(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] duty);
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit free-running PWM counter; flags the 255->0 wrap and
// registers a one-cycle period_start pulse after it.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             period_start_o
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ps_q;
  logic             tick;

  always_comb begin
    tick   = (pre_q == PRE_MAX);
    wrap_o = tick && (cnt_q == CNT_MAX);
    pre_d  = tick ? '0 : pre_q + 1'b1;
    cnt_d  = tick ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q <= '0;
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      ps_q  <= wrap_o;
    end
  end

  assign cnt_o          = cnt_q;
  assign period_start_o = ps_q;

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pad outputs as forced-low, held-high, or a shared PWM waveform,
// with the duty value shadowed so it only changes at a period boundary.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [15:0]      out_q, out_d;
  logic [15:0]      en_out, en_pwm;
  logic             pwm_sig;

  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
    .clk_i          (clk),
    .rst_i          (rst),
    .cnt_o          (cnt),
    .wrap_o         (wrap),
    .period_start_o (period_start)
  );

  // Output enable dominates; PWM select only matters for enabled bits.
  always_comb begin
    en_out  = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    duty_d  = wrap ? pwm_duty_cycle : duty_q;
    pwm_sig = pwm_level(cnt, duty_q);
    out_d   = en_out & (~en_pwm | {16{pwm_sig}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      out_q  <= '0;
    end else begin
      duty_q <= duty_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule
